// File: rtl/tap_pkg.sv
// tap_pkg: shared types and helpers for the sampled JTAG TAP.
//   tap_state_e : 16 TAP controller states in the IEEE 1149.1 encoding
//   IR_BYPASS / IR_IDCODE : instruction codes decoded inside the TAP
//   tap_next()  : TAP state transition for one tck rise
package tap_pkg;

   typedef enum logic [3:0] {
      EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
      SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
      EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
      RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
   } tap_state_e;

   localparam logic [4:0] IR_BYPASS = 5'h1F;
   localparam logic [4:0] IR_IDCODE = 5'h01;

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      case (s)
         TLR:     n = tms ? TLR    : RTI;
         RTI:     n = tms ? SEL_DR : RTI;
         SEL_DR:  n = tms ? SEL_IR : CAP_DR;
         CAP_DR:  n = tms ? EX1_DR : SH_DR;
         SH_DR:   n = tms ? EX1_DR : SH_DR;
         EX1_DR:  n = tms ? UPD_DR : PAU_DR;
         PAU_DR:  n = tms ? EX2_DR : PAU_DR;
         EX2_DR:  n = tms ? UPD_DR : SH_DR;
         UPD_DR:  n = tms ? SEL_DR : RTI;
         SEL_IR:  n = tms ? TLR    : CAP_IR;
         CAP_IR:  n = tms ? EX1_IR : SH_IR;
         SH_IR:   n = tms ? EX1_IR : SH_IR;
         EX1_IR:  n = tms ? UPD_IR : PAU_IR;
         PAU_IR:  n = tms ? EX2_IR : PAU_IR;
         EX2_IR:  n = tms ? UPD_IR : SH_IR;
         UPD_IR:  n = tms ? SEL_DR : RTI;
         default: n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_sampled_if.sv
// jtag_tap_sampled_if: JTAG pins plus the external data-register strobe bus.
//   master : the pin driver / external DR side (drives tck/tms/tdi/trst, dr_tdo)
//   slave  : the TAP controller
interface jtag_tap_sampled_if #(
   parameter int unsigned IR_WIDTH = 5
);
   logic                tck, tms, tdi, trst;
   logic                tdo, tdo_en;
   logic [IR_WIDTH-1:0] ir_out;
   logic [3:0]          tap_state;
   logic                dr_capture, dr_shift, dr_update, dr_tdi, dr_tdo;

   modport master (
      output tck, tms, tdi, trst, dr_tdo,
      input  tdo, tdo_en, ir_out, tap_state, dr_capture, dr_shift, dr_update, dr_tdi
   );

   modport slave (
      input  tck, tms, tdi, trst, dr_tdo,
      output tdo, tdo_en, ir_out, tap_state, dr_capture, dr_shift, dr_update, dr_tdi
   );
endinterface

// File: rtl/jtag_sync.sv
// jtag_sync: STAGES-deep synchronizer for one asynchronous input, plus a
// rise/fall detector on the synchronized level (one extra flop).
//   clk, rst : core clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized level
//   rise/fall: one-clk pulses on synchronized 0->1 / 1->0
// STAGES must be at least 2.
module jtag_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;
endmodule

// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP controller oversampling tck in the clk
// domain. IR, BYPASS and IDCODE live here; every other instruction is handed
// to an external data register via one-clk capture/shift/update strobes.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : slave side of jtag_tap_sampled_if (pins, status, DR strobes)
// tck high and low phases must each last at least SYNC_STAGES+1 clk.
module jtag_tap_sampled
   import tap_pkg::*;
#(
   parameter int unsigned IR_WIDTH    = 5,
   parameter logic [31:0] IDCODE_VAL  = 32'h1BEEF001,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   jtag_tap_sampled_if.slave       bus
);
   localparam int unsigned PIN_TCK = 0, PIN_TMS = 1, PIN_TDI = 2, PIN_TRST = 3;

   logic [3:0] pin_in, pin_s, pin_rise, pin_fall;

   assign pin_in = {bus.trst, bus.tdi, bus.tms, bus.tck};

   // Synchronizers run on rst only, so the trst path keeps working while
   // the TAP itself is held in reset.
   for (genvar g = 0; g < 4; g++) begin : g_sync
      jtag_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst  (rst),
         .d    (pin_in[g]),
         .q    (pin_s[g]),
         .rise (pin_rise[g]),
         .fall (pin_fall[g])
      );
   end

   // Only tck's edges matter; the tck level itself is not needed.
   logic unused_sync;
   assign unused_sync = ^{pin_s[PIN_TCK], pin_rise[3:1], pin_fall[3:1]};

   logic tck_rise, tck_fall, tms_s, tdi_s, tap_rst;
   assign tck_rise = pin_rise[PIN_TCK];
   assign tck_fall = pin_fall[PIN_TCK];
   assign tms_s    = pin_s[PIN_TMS];
   assign tdi_s    = pin_s[PIN_TDI];
   assign tap_rst  = rst | pin_s[PIN_TRST];

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_out_q, ir_out_d;
   logic [31:0]         id_sr_q, id_sr_d;
   logic                byp_q, byp_d, tdo_q, tdo_d, tdo_en_q, tdo_en_d;
   logic                dr_capture_q, dr_capture_d, dr_shift_q, dr_shift_d;
   logic                dr_update_q, dr_update_d, dr_tdi_q, dr_tdi_d;

   logic is_idc, is_byp, is_ext;
   assign is_idc = (ir_out_q == IR_WIDTH'(IR_IDCODE));
   assign is_byp = (ir_out_q == IR_WIDTH'(IR_BYPASS));
   assign is_ext = ~is_idc & ~is_byp;

   always_comb begin
      state_d      = state_q;
      ir_sr_d      = ir_sr_q;
      ir_out_d     = ir_out_q;
      id_sr_d      = id_sr_q;
      byp_d        = byp_q;
      tdo_d        = tdo_q;
      tdo_en_d     = tdo_en_q;
      dr_capture_d = 1'b0;
      dr_shift_d   = 1'b0;
      dr_update_d  = 1'b0;
      dr_tdi_d     = dr_tdi_q;

      if (tck_rise) begin
         // Actions belong to the state we are leaving.
         state_d = tap_next(state_q, tms_s);
         case (state_q)
            CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
            SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
            CAP_DR: begin
               if (is_idc)      id_sr_d      = IDCODE_VAL;
               else if (is_byp) byp_d        = 1'b0;
               else             dr_capture_d = 1'b1;
            end
            SH_DR: begin
               if (is_idc)      id_sr_d = {tdi_s, id_sr_q[31:1]};
               else if (is_byp) byp_d   = tdi_s;
               else begin
                  dr_shift_d = 1'b1;
                  dr_tdi_d   = tdi_s;
               end
            end
            default: ;
         endcase
      end else if (tck_fall) begin
         if (state_q == UPD_IR) ir_out_d = ir_sr_q;
         if (state_q == UPD_DR && is_ext) dr_update_d = 1'b1;
         case (state_q)
            SH_IR:   tdo_d = ir_sr_q[0];
            SH_DR:   tdo_d = is_idc ? id_sr_q[0] : (is_byp ? byp_q : bus.dr_tdo);
            default: tdo_d = 1'b0;
         endcase
         tdo_en_d = (state_q == SH_IR) || (state_q == SH_DR);
      end

      if (state_q == TLR) ir_out_d = IR_WIDTH'(IR_IDCODE);
   end

   always_ff @(posedge clk) begin
      if (tap_rst) begin
         state_q      <= TLR;
         ir_sr_q      <= '0;
         ir_out_q     <= IR_WIDTH'(IR_IDCODE);
         id_sr_q      <= '0;
         byp_q        <= 1'b0;
         tdo_q        <= 1'b0;
         tdo_en_q     <= 1'b0;
         dr_capture_q <= 1'b0;
         dr_shift_q   <= 1'b0;
         dr_update_q  <= 1'b0;
         dr_tdi_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ir_sr_q      <= ir_sr_d;
         ir_out_q     <= ir_out_d;
         id_sr_q      <= id_sr_d;
         byp_q        <= byp_d;
         tdo_q        <= tdo_d;
         tdo_en_q     <= tdo_en_d;
         dr_capture_q <= dr_capture_d;
         dr_shift_q   <= dr_shift_d;
         dr_update_q  <= dr_update_d;
         dr_tdi_q     <= dr_tdi_d;
      end
   end

   assign bus.tdo        = tdo_q;
   assign bus.tdo_en     = tdo_en_q;
   assign bus.ir_out     = ir_out_q;
   assign bus.tap_state  = state_q;
   assign bus.dr_capture = dr_capture_q;
   assign bus.dr_shift   = dr_shift_q;
   assign bus.dr_update  = dr_update_q;
   assign bus.dr_tdi     = dr_tdi_q;
endmodule

// File: tb/tb_jtag_tap_sampled.sv
// tb_jtag_tap_sampled: directed bit-bang scans against jtag_tap_sampled.
// Expected tdo bits and dr_tdi bits are queued as stimulus is issued and
// popped as the DUT produces them; an 8-bit external DR model answers
// dr_capture/dr_shift.
module tb_jtag_tap_sampled;
   localparam logic [31:0] IDC     = 32'h1BEEF001;
   localparam logic [7:0]  CAP_VAL = 8'hA5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   jtag_tap_sampled_if #(.IR_WIDTH(5)) bus ();

   jtag_tap_sampled #(.IR_WIDTH(5), .IDCODE_VAL(IDC), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_tdo_q[$];
   logic exp_tdi_q[$];
   int   n_cap = 0, n_shift = 0, n_upd = 0;
   logic [7:0] ext_sr = 8'h00;

   assign bus.dr_tdo = ext_sr[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // External DR model and strobe counters.
   always @(negedge clk) begin
      if (bus.dr_capture === 1'b1) begin
         n_cap++;
         ext_sr = CAP_VAL;
      end
      if (bus.dr_shift === 1'b1) begin
         n_shift++;
         if (exp_tdi_q.size() == 0) chk("dr_shift_unexpected", 32'd1, 32'd0);
         else chk("dr_tdi", {31'd0, bus.dr_tdi}, {31'd0, exp_tdi_q.pop_front()});
         ext_sr = {bus.dr_tdi, ext_sr[7:1]};
      end
      if (bus.dr_update === 1'b1) n_upd++;
   end

   // One tck period: fall, 6 clk low, sample tdo/tdo_en, rise, 6 clk high.
   task automatic tck_cyc(input logic tms_v, input logic tdi_v,
                          output logic tdo_s, output logic en_s);
      bus.tck = 1'b0;
      bus.tms = tms_v;
      bus.tdi = tdi_v;
      repeat (6) @(negedge clk);
      tdo_s = bus.tdo;
      en_s  = bus.tdo_en;
      bus.tck = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic tms_seq(input int n, input logic [7:0] bits);
      logic t, e;
      for (int i = 0; i < n; i++) tck_cyc(bits[i], 1'b0, t, e);
   endtask

   // Shift n bits (LSB first); tms=1 on the last bit when ex is set.
   task automatic scan(input int n, input logic [63:0] bits, input logic ex, input string tag);
      logic t, e, x;
      for (int i = 0; i < n; i++) begin
         tck_cyc(ex && (i == n - 1), bits[i], t, e);
         x = exp_tdo_q.pop_front();
         chk({tag, "_tdo"}, {31'd0, t}, {31'd0, x});
         chk({tag, "_tdo_en"}, {31'd0, e}, 32'd1);
      end
   endtask

   initial begin
      int c0, s0, u0;
      logic [31:0] idc_v;
      logic [7:0]  cap_v;
      logic [63:0] rnd;
      idc_v = IDC;
      cap_v = CAP_VAL;

      rst = 1'b1;
      bus.tck = 1'b0; bus.tms = 1'b0; bus.tdi = 1'b0; bus.trst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", {28'd0, bus.tap_state}, 32'hF);
      chk("rst_ir", {27'd0, bus.ir_out}, 32'h01);
      chk("rst_tdo", {30'd0, bus.tdo, bus.tdo_en}, 32'd0);
      chk("rst_dr", {28'd0, bus.dr_capture, bus.dr_shift, bus.dr_update, bus.dr_tdi}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // IDCODE read from TLR
      tms_seq(4, 8'b0010);
      chk("idc_state", {28'd0, bus.tap_state}, 32'h2);
      for (int i = 0; i < 32; i++) exp_tdo_q.push_back(idc_v[i]);
      scan(32, 64'd0, 1'b1, "idcode");
      tms_seq(2, 8'b01);
      chk("idc_rti", {28'd0, bus.tap_state}, 32'hC);
      chk("idc_no_dr", n_cap + n_shift + n_upd, 32'd0);

      // BYPASS
      tms_seq(4, 8'b0011);
      chk("ir_state", {28'd0, bus.tap_state}, 32'hA);
      exp_tdo_q.push_back(1'b1);
      for (int i = 0; i < 4; i++) exp_tdo_q.push_back(1'b0);
      scan(5, 64'h1F, 1'b1, "ir_byp");
      tms_seq(2, 8'b01);
      chk("ir_byp_out", {27'd0, bus.ir_out}, 32'h1F);
      tms_seq(3, 8'b001);
      exp_tdo_q.push_back(1'b0); exp_tdo_q.push_back(1'b1);
      exp_tdo_q.push_back(1'b0); exp_tdo_q.push_back(1'b1);
      scan(4, 64'b1101, 1'b1, "bypass");
      tms_seq(2, 8'b01);
      chk("byp_no_dr", n_cap + n_shift + n_upd, 32'd0);

      // IR capture + external DR
      tms_seq(4, 8'b0011);
      exp_tdo_q.push_back(1'b1);
      for (int i = 0; i < 4; i++) exp_tdo_q.push_back(1'b0);
      scan(5, 64'h11, 1'b1, "ir_ext");
      tms_seq(2, 8'b01);
      chk("ir_ext_out", {27'd0, bus.ir_out}, 32'h11);
      c0 = n_cap; s0 = n_shift; u0 = n_upd;
      tms_seq(3, 8'b001);
      for (int i = 0; i < 8; i++) begin
         exp_tdo_q.push_back(cap_v[i]);
         exp_tdi_q.push_back(((8'h3C >> i) & 8'h01) != 8'h00);
      end
      scan(8, 64'h3C, 1'b1, "ext");
      tms_seq(2, 8'b01);
      chk("ext_cap_cnt", n_cap - c0, 32'd1);
      chk("ext_shift_cnt", n_shift - s0, 32'd8);
      chk("ext_upd_cnt", n_upd - u0, 32'd1);
      chk("ext_sr", {24'd0, ext_sr}, 32'h3C);
      chk("ext_tdi_left", exp_tdi_q.size(), 32'd0);

      // TMS reset from PAU_IR
      tms_seq(6, 8'b010011);
      chk("pau_ir", {28'd0, bus.tap_state}, 32'hB);
      tms_seq(5, 8'b11111);
      chk("tms_rst_state", {28'd0, bus.tap_state}, 32'hF);
      chk("tms_rst_ir", {27'd0, bus.ir_out}, 32'h01);

      // trst in the middle of an IDCODE scan
      c0 = n_cap; s0 = n_shift; u0 = n_upd;
      tms_seq(4, 8'b0010);
      rnd = {$urandom, $urandom};
      for (int i = 0; i < 10; i++) exp_tdo_q.push_back(idc_v[i]);
      scan(10, rnd, 1'b0, "pre_trst");
      bus.trst = 1'b1;
      repeat (3) @(negedge clk);
      chk("trst_state", {28'd0, bus.tap_state}, 32'hF);
      chk("trst_tdo", {30'd0, bus.tdo, bus.tdo_en}, 32'd0);
      chk("trst_ir", {27'd0, bus.ir_out}, 32'h01);
      tms_seq(3, 8'b000);
      chk("trst_hold", {28'd0, bus.tap_state}, 32'hF);
      bus.trst = 1'b0;
      repeat (4) @(negedge clk);
      chk("trst_no_dr", (n_cap - c0) + (n_shift - s0) + (n_upd - u0), 32'd0);
      tms_seq(4, 8'b0010);
      rnd = {$urandom, $urandom};
      for (int i = 0; i < 32; i++) exp_tdo_q.push_back(idc_v[i]);
      scan(32, rnd, 1'b1, "idcode2");
      tms_seq(2, 8'b01);
      chk("post_rti", {28'd0, bus.tap_state}, 32'hC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
